// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one single-port memory between instruction fetch and the memory stage.
// Define MEM_PORT_ARB_PERF_EN to add saturating wait-cycle counters (perf_if_wait / perf_dm_wait).
module mem_port_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic [DATA_WIDTH-1:0]   InstrF,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  input  logic                    ext_stall,
  output logic                    mem_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
`ifdef MEM_PORT_ARB_PERF_EN
  output logic [PERF_WIDTH-1:0]   perf_if_wait,
  output logic [PERF_WIDTH-1:0]   perf_dm_wait,
`endif
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // Byte enables need whole bytes; counters need at least one bit.
  if ((DATA_WIDTH % 8) != 0 || PERF_WIDTH == 0) begin : g_bad_cfg
    $error("mem_port_arb: unsupported DATA_WIDTH/PERF_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    if_done_q, if_done_d;
  logic                    dm_done_q, dm_done_d;
  logic                    if_discard_q, if_discard_d;

  logic pend_if, pend_dm, advance;
  logic if_cpl, dm_cpl, discard_now;
  logic launch_if, launch_dm;

  // Outstanding work and completion qualifiers for this cycle.
  always_comb begin
    pend_if     = if_req & ~if_done_q;
    pend_dm     = dm_req & ~dm_done_q;
    advance     = ~(pend_if | pend_dm) & ~ext_stall;
    if_cpl      = (state_q == IF_BUSY) & mem_ready;
    dm_cpl      = (state_q == DM_BUSY) & mem_ready;
    discard_now = if_discard_q | if_flush;
  end

  assign mem_stall = pend_if | pend_dm;

  // Next-state, done flags, response buffers and request launch.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    instr_d      = instr_q;
    rdata_d      = rdata_q;
    if_done_d    = if_done_q;
    dm_done_d    = dm_done_q;
    if_discard_d = if_discard_q;
    launch_if    = 1'b0;
    launch_dm    = 1'b0;

    if (advance) begin
      if_done_d = 1'b0;
      dm_done_d = 1'b0;
    end

    if (dm_cpl) begin
      dm_done_d = 1'b1;
      if (!mem_we_q) begin
        rdata_d = mem_rdata;
      end
    end

    // A fetch redirected while in flight completes into the void.
    if (if_cpl) begin
      if (!discard_now) begin
        instr_d   = mem_rdata;
        if_done_d = 1'b1;
      end
      if_discard_d = 1'b0;
    end else if ((state_q == IF_BUSY) && if_flush) begin
      if_discard_d = 1'b1;
    end

    if (if_flush) begin
      if_done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        launch_dm = pend_dm;
        launch_if = ~pend_dm & pend_if;
      end
      IF_BUSY, DM_BUSY: begin
        // Chain the other requester straight onto the port, data side first.
        if (mem_ready) begin
          launch_dm = dm_req & ~dm_done_d;
          launch_if = ~launch_dm & if_req & ~if_done_d;
          if (!launch_dm && !launch_if) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    if (launch_dm) begin
      state_d     = DM_BUSY;
      mem_req_d   = 1'b1;
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      mem_be_d    = dm_be;
    end else if (launch_if) begin
      state_d     = IF_BUSY;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_be_d    = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      instr_q      <= '0;
      rdata_q      <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      if_discard_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      instr_q      <= instr_d;
      rdata_q      <= rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      if_discard_q <= if_discard_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign InstrF    = instr_q;
  assign ReadDataM = rdata_q;

`ifdef MEM_PORT_ARB_PERF_EN
  logic [PERF_WIDTH-1:0] perf_if_q, perf_if_d;
  logic [PERF_WIDTH-1:0] perf_dm_q, perf_dm_d;

  // Saturating counts of cycles each requester spends waiting.
  always_comb begin
    perf_if_d = perf_if_q;
    perf_dm_d = perf_dm_q;
    if (pend_if && (perf_if_q != '1)) begin
      perf_if_d = perf_if_q + PERF_WIDTH'(1);
    end
    if (pend_dm && (perf_dm_q != '1)) begin
      perf_dm_d = perf_dm_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_dm_q <= perf_dm_d;
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_dm_wait = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus random slots against a transaction-level memory model.
module tb_mem_port_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] InstrF;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [BW-1:0] dm_be;
  logic [DW-1:0] ReadDataM;
  logic          ext_stall;
  logic          mem_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PERF_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .InstrF(InstrF),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .ReadDataM(ReadDataM), .ext_stall(ext_stall), .mem_stall(mem_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int            lat;
  } xact_t;

  int            errors = 0;
  int            checks = 0;
  xact_t         exp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            lat_cnt = 0;
  logic [DW-1:0] exp_instr = '0;
  logic [DW-1:0] exp_rd = '0;
  int            flush_at = -1;
  logic [AW-1:0] flush_addr = '0;
  int            flush_lat = 1;
  int            rst_at = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Memory side of one cycle: answer the pending request when its latency expires, then sample stall.
  task automatic mid(output bit st);
    logic [DW-1:0] v;
    mem_ready = 1'b0;
    mem_rdata = DW'($urandom);
    if (mem_req === 1'b1) begin
      check("req_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        lat_cnt++;
        check("req_addr", 64'(mem_addr), 64'(exp_q[0].addr));
        check("req_be", 64'(mem_be), 64'(exp_q[0].be));
        check("req_we", 64'(mem_we), 64'(exp_q[0].we));
        if (lat_cnt >= exp_q[0].lat) begin
          if (exp_q[0].we) begin
            check("req_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
            v = rd(exp_q[0].addr);
            for (int b = 0; b < int'(BW); b++)
              if (exp_q[0].be[b]) v[8*b +: 8] = exp_q[0].wdata[8*b +: 8];
            mem[exp_q[0].addr] = v;
          end else begin
            mem_rdata = rd(exp_q[0].addr);
          end
          mem_ready = 1'b1;
          lat_cnt = 0;
          void'(exp_q.pop_front());
        end
      end
    end
    #1;
    st = mem_stall;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  // One pipeline slot: hold the requests until the arbiter releases the stall, then advance.
  task automatic run_slot(input bit ifr, input logic [AW-1:0] ia, input bit dmr, input bit we,
                          input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic [BW-1:0] be,
                          input int lat_dm, input int lat_if, input int ext_n);
    int stalls = 0;
    int cyc = 0;
    bit st;
    logic [AW-1:0] fin_ia = ia;
    logic [DW-1:0] load_val = rd(da);
    int exp_stalls = (ifr || dmr) ? 1 + (dmr ? lat_dm : 0) + (ifr ? lat_if : 0) : 0;
    if (dmr) exp_q.push_back('{we, da, wd, be, lat_dm});
    if (ifr) exp_q.push_back('{1'b0, ia, '0, '1, lat_if});
    if_req = ifr; if_addr = ia; dm_req = dmr; dm_we = we; dm_addr = da; dm_wdata = wd; dm_be = be;
    while (1) begin
      if_flush = (cyc == flush_at);
      if (cyc == flush_at) begin
        if_addr = flush_addr;
        fin_ia = flush_addr;
        exp_q.push_back('{1'b0, flush_addr, '0, '1, flush_lat});
      end
      rst = (cyc == rst_at);
      if (cyc == rst_at + 1 && rst_at >= 0) lat_cnt = 0;
      mid(st);
      if (cyc == rst_at + 1 && rst_at >= 0) begin
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        check("rst_instr", 64'(InstrF), 64'd0);
        check("rst_rdata", 64'(ReadDataM), 64'd0);
        check("rst_stall_pending", 64'(st), 64'(ifr | dmr));
        exp_instr = '0;
        exp_rd = '0;
        stalls = 0;
      end
      if (flush_at >= 0 && cyc > flush_at && st)
        check("flush_no_stale_instr", 64'(InstrF), 64'(exp_instr));
      if (!st) break;
      stalls++;
      ext_stall = 1'($urandom_range(0, 1));
      edge_();
      cyc++;
      if (cyc > 300) begin
        check("stall_timeout", 64'd1, 64'd0);
        break;
      end
    end
    if_flush = 1'b0;
    rst = 1'b0;
    if (dmr && !we) exp_rd = load_val;
    if (ifr) exp_instr = rd(fin_ia);
    check("fall_mem_req", 64'(mem_req), 64'd0);
    check("fall_instr", 64'(InstrF), 64'(exp_instr));
    check("fall_rdata", 64'(ReadDataM), 64'(exp_rd));
    check("xacts_left", 64'(exp_q.size()), 64'd0);
    if (flush_at < 0) check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    for (int k = 0; k < ext_n; k++) begin
      ext_stall = 1'b1;
      edge_();
      mid(st);
      check("hold_stall", 64'(st), 64'd0);
      check("hold_no_req", 64'(mem_req), 64'd0);
      check("hold_instr", 64'(InstrF), 64'(exp_instr));
      check("hold_rdata", 64'(ReadDataM), 64'(exp_rd));
    end
    ext_stall = 1'b0;
    edge_();
    flush_at = -1;
    rst_at = -1;
    exp_q.delete();
    lat_cnt = 0;
  endtask

  initial begin
    bit st;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    ext_stall = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mid(st);
    check("reset_stall", 64'(st), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_mem_be", 64'(mem_be), 64'd0);
    check("reset_instr", 64'(InstrF), 64'd0);
    check("reset_rdata", 64'(ReadDataM), 64'd0);
    edge_();

    // Single fetch, memory ready in the first request cycle.
    mem[32'h100] = 32'h00500093;
    run_slot(1, 32'h100, 0, 0, '0, '0, '0, 1, 1, 0);
    check("fetch_instr_value", 64'(InstrF), 64'h00500093);

    // Fetch and store together: store first, fetch chained behind it.
    run_slot(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 4'h3, 1, 1, 0);

    // Slow load.
    run_slot(0, '0, 1, 0, 32'h2000, '0, 4'hF, 3, 1, 0);

    // Fetch redirected mid-flight, and redirected on its completion cycle.
    flush_at = 2; flush_addr = 32'h200; flush_lat = 1;
    run_slot(1, 32'h108, 0, 0, '0, '0, '0, 1, 3, 0);
    flush_at = 1; flush_addr = 32'h204; flush_lat = 2;
    run_slot(1, 32'h10C, 0, 0, '0, '0, '0, 1, 1, 0);

    // External stall holds a completed fetch without repeating it.
    run_slot(1, 32'h300, 0, 0, '0, '0, '0, 1, 1, 3);
    run_slot(1, 32'h300, 0, 0, '0, '0, '0, 1, 2, 0);

    // Reset while a load is outstanding.
    rst_at = 3;
    run_slot(0, '0, 1, 0, 32'h3000, '0, 4'hF, 6, 1, 0);

    // Random slots over a small address pool so stores feed later loads.
    for (int s = 0; s < 40; s++) begin
      logic [AW-1:0] ra, rb;
      bit we;
      ra = 32'h1000 + AW'({$urandom_range(0, 7), 2'b00});
      rb = 32'h1000 + AW'({$urandom_range(0, 7), 2'b00});
      we = 1'($urandom_range(0, 1));
      run_slot(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), we, rb, DW'($urandom),
               we ? BW'($urandom_range(1, 15)) : BW'(4'hF),
               $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
